// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: width helpers and default-configuration widths.
// The top and the adder tree derive their own widths from their parameters with these helpers.
package mac_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Width of a full-precision signed product of two dw-bit operands.
  function automatic int prod_w(input int dw);
    return 2 * dw;
  endfunction

  // LSB position of lane k in a packed vector of w-bit lanes.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

  localparam int N_LANE_DEF = 27;
  localparam int DW_DEF     = 8;
  localparam int PW         = prod_w(DW_DEF);
  localparam int T          = clog2(N_LANE_DEF);
  localparam int SW         = PW + T;

endpackage

// File: rtl/mac_adder_tree_p.sv
// Pipelined signed reduction of N lanes of IW bits: one register per level, clog2(N) levels.
// vld/first/last travel in a parallel shift register so they emerge with their sum.
module mac_adder_tree_p
  import mac_pkg::*;
#(
  parameter int N  = 27,
  parameter int IW = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      vld_i,
  input  logic                      first_i,
  input  logic                      last_i,
  input  logic [N*IW-1:0]           in_i,
  output logic [IW+clog2(N)-1:0]    sum_o,
  output logic                      vld_o,
  output logic                      first_o,
  output logic                      last_o
);

  localparam int LV = clog2(N);
  localparam int OW = IW + LV;

  // lvl[l] holds the operands feeding level l; one spare slot keeps the pair index in range.
  logic signed [OW-1:0] lvl    [LV+1][N+1];
  logic signed [OW-1:0] node_d [LV][N];
  logic signed [OW-1:0] node_q [LV][N];
  logic [2:0]           sb_d   [LV];
  logic [2:0]           sb_q   [LV];

  function automatic int lvl_cnt(input int l);
    return (N + (1 << l) - 1) >> l;
  endfunction

  always_comb begin
    for (int l = 0; l <= LV; l++) begin
      for (int j = 0; j <= N; j++) begin
        lvl[l][j] = '0;
      end
    end
    for (int j = 0; j < N; j++) begin
      lvl[0][j] = OW'($signed(in_i[lane_lo(j, IW) +: IW]));
    end
    for (int l = 1; l <= LV; l++) begin
      for (int j = 0; j < N; j++) begin
        lvl[l][j] = node_q[l-1][j];
      end
    end
  end

  // An odd element at the end of a level is carried through unchanged.
  always_comb begin
    for (int l = 0; l < LV; l++) begin
      for (int j = 0; j < N; j++) begin
        node_d[l][j] = '0;
      end
      for (int j = 0; j < (N + 1) / 2; j++) begin
        if (2 * j + 1 < lvl_cnt(l)) begin
          node_d[l][j] = lvl[l][2*j] + lvl[l][2*j+1];
        end else if (2 * j < lvl_cnt(l)) begin
          node_d[l][j] = lvl[l][2*j];
        end
      end
    end
  end

  always_comb begin
    sb_d[0] = {vld_i, first_i, last_i};
    for (int l = 1; l < LV; l++) begin
      sb_d[l] = sb_q[l-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int l = 0; l < LV; l++) begin
        sb_q[l] <= '0;
        for (int j = 0; j < N; j++) begin
          node_q[l][j] <= '0;
        end
      end
    end else begin
      sb_q   <= sb_d;
      node_q <= node_d;
    end
  end

  assign sum_o   = node_q[LV-1][0];
  assign vld_o   = sb_q[LV-1][2];
  assign first_o = sb_q[LV-1][1];
  assign last_o  = sb_q[LV-1][0];

endmodule

// File: rtl/mac_acc_array.sv
// N_LANE signed multiply, pipelined adder tree, then frame accumulation seeded by a bias.
// One accumulated result (with sticky overflow) is emitted per frame on the last beat.
module mac_acc_array
  import mac_pkg::*;
#(
  parameter int N_LANE = 27,
  parameter int DW     = 8,
  parameter int ACCW   = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   vld_i,
  input  logic                   first_i,
  input  logic                   last_i,
  input  logic [N_LANE*DW-1:0]   win,
  input  logic [N_LANE*DW-1:0]   din,
  input  logic [ACCW-1:0]        bias_i,
  output logic [ACCW-1:0]        acc_o,
  output logic                   vld_o,
  output logic                   ovf_o,
  output logic                   err_o
);

  localparam int LPW = prod_w(DW);
  localparam int LT  = clog2(N_LANE);
  localparam int LSW = LPW + LT;

  // Valid semantics: there is no ready. A beat with vld_i high is consumed on that clock edge;
  // with vld_i low the data and first/last inputs are ignored and the pipeline carries a bubble.
  logic [N_LANE*LPW-1:0] prod_d, prod_q;
  logic                  m_vld_d, m_vld_q;
  logic                  m_first_d, m_first_q;
  logic                  m_last_d, m_last_q;
  logic [ACCW-1:0]       bias_d [LT+1];
  logic [ACCW-1:0]       bias_q [LT+1];

  logic [LSW-1:0]        t_sum;
  logic                  t_vld, t_first, t_last;

  logic [ACCW-1:0]       sum_ext, base, add;
  logic                  step_ovf;
  logic [ACCW-1:0]       acc_d, acc_q;
  logic                  acc_ovf_d, acc_ovf_q;
  logic                  open_d, open_q;
  logic [ACCW-1:0]       acc_o_d, acc_o_q;
  logic                  ovf_o_d, ovf_o_q;
  logic                  vld_o_d, vld_o_q;
  logic                  err_o_d, err_o_q;

  always_comb begin
    prod_d = '0;
    for (int k = 0; k < N_LANE; k++) begin
      prod_d[lane_lo(k, LPW) +: LPW] = $signed(win[lane_lo(k, DW) +: DW]) *
                                       $signed(din[lane_lo(k, DW) +: DW]);
    end
    m_vld_d   = vld_i;
    m_first_d = vld_i & first_i;
    m_last_d  = vld_i & last_i;
  end

  // The bias rides a delay line matched to the multiplier plus tree depth.
  always_comb begin
    bias_d[0] = bias_i;
    for (int i = 1; i <= LT; i++) begin
      bias_d[i] = bias_q[i-1];
    end
  end

  mac_adder_tree_p #(
    .N  (N_LANE),
    .IW (LPW)
  ) u_tree (
    .clk     (clk),
    .rstn    (rstn),
    .vld_i   (m_vld_q),
    .first_i (m_first_q),
    .last_i  (m_last_q),
    .in_i    (prod_q),
    .sum_o   (t_sum),
    .vld_o   (t_vld),
    .first_o (t_first),
    .last_o  (t_last)
  );

  // A first beat always restarts; any other beat accumulates even without an open frame.
  always_comb begin
    sum_ext  = ACCW'($signed(t_sum));
    base     = t_first ? bias_q[LT] : acc_q;
    add      = base + sum_ext;
    step_ovf = (base[ACCW-1] == sum_ext[ACCW-1]) && (add[ACCW-1] != base[ACCW-1]);

    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    open_d    = open_q;
    acc_o_d   = acc_o_q;
    ovf_o_d   = ovf_o_q;
    vld_o_d   = 1'b0;
    err_o_d   = 1'b0;
    if (t_vld) begin
      err_o_d   = t_first ? open_q : !open_q;
      acc_d     = add;
      acc_ovf_d = (t_first ? 1'b0 : acc_ovf_q) | step_ovf;
      open_d    = !t_last;
      if (t_last) begin
        acc_o_d = add;
        ovf_o_d = acc_ovf_d;
        vld_o_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prod_q    <= '0;
      m_vld_q   <= 1'b0;
      m_first_q <= 1'b0;
      m_last_q  <= 1'b0;
      for (int i = 0; i <= LT; i++) begin
        bias_q[i] <= '0;
      end
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      open_q    <= 1'b0;
      acc_o_q   <= '0;
      ovf_o_q   <= 1'b0;
      vld_o_q   <= 1'b0;
      err_o_q   <= 1'b0;
    end else begin
      prod_q    <= prod_d;
      m_vld_q   <= m_vld_d;
      m_first_q <= m_first_d;
      m_last_q  <= m_last_d;
      bias_q    <= bias_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      open_q    <= open_d;
      acc_o_q   <= acc_o_d;
      ovf_o_q   <= ovf_o_d;
      vld_o_q   <= vld_o_d;
      err_o_q   <= err_o_d;
    end
  end

  assign acc_o = acc_o_q;
  assign vld_o = vld_o_q;
  assign ovf_o = ovf_o_q;
  assign err_o = err_o_q;

endmodule

// File: tb/tb_mac_acc_array.sv
// Bench for mac_acc_array: directed and random beats scored against a frame-level model
// (integer dot products, range-checked accumulation, per-cycle event schedule).
module tb_mac_acc_array;

  localparam int N  = 27;
  localparam int DW = 8;
  localparam int L  = 7;

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic              vld_i   = 1'b0;
  logic              first_i = 1'b0;
  logic              last_i  = 1'b0;
  logic [N*DW-1:0]   win     = '0;
  logic [N*DW-1:0]   din     = '0;
  logic [31:0]       bias_i  = '0;
  logic [20:0]       bias21  = '0;
  logic [31:0]       acc_o;
  logic              vld_o, ovf_o, err_o;
  logic [20:0]       acc21;
  logic              vld21, ovf21, err21;

  mac_acc_array #(.N_LANE(N), .DW(DW), .ACCW(32)) dut (
    .clk(clk), .rstn(rstn), .vld_i(vld_i), .first_i(first_i), .last_i(last_i),
    .win(win), .din(din), .bias_i(bias_i),
    .acc_o(acc_o), .vld_o(vld_o), .ovf_o(ovf_o), .err_o(err_o)
  );

  mac_acc_array #(.N_LANE(N), .DW(DW), .ACCW(21)) dut21 (
    .clk(clk), .rstn(rstn), .vld_i(vld_i), .first_i(first_i), .last_i(last_i),
    .win(win), .din(din), .bias_i(bias21),
    .acc_o(acc21), .vld_o(vld21), .ovf_o(ovf21), .err_o(err21)
  );

  // reference model and scoreboard
  typedef struct {
    int due;
    bit vld;
    bit err;
    bit ovf;
  } ev_t;

  ev_t               ev_q[$];
  logic [31:0]       exp_q[$];
  logic signed [7:0] w_a [N];
  logic signed [7:0] x_a [N];
  int                m_acc;
  bit                m_ovf, m_open;
  logic [31:0]       h_acc;
  bit                h_ovf;
  int                cyc    = 0;
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    ev_t ev;
    bit  e_vld, e_err;
    e_vld = 1'b0;
    e_err = 1'b0;
    if (ev_q.size() > 0 && ev_q[0].due == cyc) begin
      ev    = ev_q.pop_front();
      e_vld = ev.vld;
      e_err = ev.err;
      if (ev.vld) begin
        h_acc = exp_q.pop_front();
        h_ovf = ev.ovf;
      end
    end
    chk("vld_o", {31'b0, vld_o}, {31'b0, e_vld});
    chk("err_o", {31'b0, err_o}, {31'b0, e_err});
    chk("acc_o", acc_o, h_acc);
    chk("ovf_o", {31'b0, ovf_o}, {31'b0, h_ovf});
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  // driver tasks
  task automatic do_reset(input int n);
    rstn    = 1'b0;
    vld_i   = 1'b0;
    first_i = 1'b0;
    last_i  = 1'b0;
    ev_q.delete();
    exp_q.delete();
    m_acc  = 0;
    m_ovf  = 1'b0;
    m_open = 1'b0;
    h_acc  = '0;
    h_ovf  = 1'b0;
    repeat (n) tick();
    rstn = 1'b1;
  endtask

  task automatic set_lanes(input logic signed [7:0] w, input logic signed [7:0] x);
    for (int k = 0; k < N; k++) begin
      w_a[k] = w;
      x_a[k] = x;
    end
  endtask

  task automatic rand_lanes();
    for (int k = 0; k < N; k++) begin
      w_a[k] = 8'($urandom);
      x_a[k] = 8'($urandom);
    end
  endtask

  task automatic beat(input bit first, input bit last, input logic [31:0] bias);
    int     sum;
    longint base, t;
    bit     err, step;
    ev_t    ev;
    sum = 0;
    for (int k = 0; k < N; k++) begin
      sum += int'(w_a[k]) * int'(x_a[k]);
      win[k*DW +: DW] = w_a[k];
      din[k*DW +: DW] = x_a[k];
    end
    err  = first ? m_open : !m_open;
    base = first ? longint'($signed(bias)) : longint'(m_acc);
    t    = base + longint'(sum);
    step = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    m_ovf  = (first ? 1'b0 : m_ovf) | step;
    m_acc  = t[31:0];
    m_open = !last;
    if (err || last) begin
      ev.due = cyc + L;
      ev.vld = last;
      ev.err = err;
      ev.ovf = m_ovf;
      ev_q.push_back(ev);
      if (last) exp_q.push_back(m_acc);
    end
    vld_i   = 1'b1;
    first_i = first;
    last_i  = last;
    bias_i  = bias;
    tick();
    vld_i   = 1'b0;
    first_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) begin
      win     = {N{8'($urandom)}};
      din     = {N{8'($urandom)}};
      first_i = 1'($urandom);
      last_i  = 1'($urandom);
      bias_i  = $urandom;
      tick();
    end
    first_i = 1'b0;
    last_i  = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset(3);
    chk("reset_acc21", {11'b0, acc21}, 32'd0);
    chk("reset_vld21", {31'b0, vld21}, 32'd0);
    bubble(2);

    // all ones, single beat, bias 0 -> 27 after L cycles
    set_lanes(8'sd1, 8'sd1);
    beat(1'b1, 1'b1, 32'd0);
    bubble(8);

    // most negative operands, bias -5 -> 442363
    set_lanes(8'h80, 8'h80);
    beat(1'b1, 1'b1, 32'hFFFF_FFFB);
    bubble(8);
    chk("neg_result", h_acc, 32'd442363);

    // four beats with bubbles 0/3/1, bias 10 -> 442
    set_lanes(8'sd2, 8'sd2);
    beat(1'b1, 1'b0, 32'd10);
    beat(1'b0, 1'b0, 32'd0);
    bubble(3);
    beat(1'b0, 1'b0, 32'd0);
    bubble(1);
    beat(1'b0, 1'b1, 32'd0);
    bubble(8);
    chk("multi_beat_result", h_acc, 32'd442);

    // back-to-back frames: 27 then -54
    set_lanes(8'sd1, 8'sd1);
    beat(1'b1, 1'b1, 32'd0);
    set_lanes(8'sd1, 8'hFF);
    beat(1'b1, 1'b0, 32'd0);
    beat(1'b0, 1'b1, 32'd0);
    bubble(8);
    chk("b2b_result", h_acc, 32'hFFFF_FFCA);

    // first while a frame is open: partial discarded
    rand_lanes();
    beat(1'b1, 1'b0, $urandom);
    rand_lanes();
    beat(1'b0, 1'b0, 32'd0);
    rand_lanes();
    beat(1'b1, 1'b0, $urandom);
    rand_lanes();
    beat(1'b0, 1'b1, 32'd0);
    bubble(8);

    // lone last after reset accumulates onto zero
    do_reset(2);
    rand_lanes();
    beat(1'b0, 1'b1, $urandom);
    bubble(8);

    // overflow on a 21-bit accumulator: (2^20-1) + 27 wraps to -2^20+26
    do_reset(2);
    set_lanes(8'sd1, 8'sd1);
    bias21 = 21'h0F_FFFF;
    beat(1'b1, 1'b1, 32'h000F_FFFF);
    bias21 = '0;
    for (int i = 1; i < L; i++) begin
      tick();
      if (i < L - 1) chk("ovf21_early_vld", {31'b0, vld21}, 32'd0);
    end
    chk("ovf21_vld", {31'b0, vld21}, 32'd1);
    chk("ovf21_acc", {11'b0, acc21}, 32'h0010_001A);
    chk("ovf21_flag", {31'b0, ovf21}, 32'd1);
    chk("ovf21_err", {31'b0, err21}, 32'd0);
    bubble(3);

    // reset with a frame in flight: no output for it
    rand_lanes();
    beat(1'b1, 1'b0, $urandom);
    rand_lanes();
    beat(1'b0, 1'b1, $urandom);
    bubble(2);
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_reset_vld21", {31'b0, vld21}, 32'd0);
    end

    // random frames, including framing errors and bubbles
    for (int n = 0; n < 300; n++) begin
      rand_lanes();
      beat($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom);
      if ($urandom_range(0, 9) < 3) bubble($urandom_range(1, 3));
    end
    bubble(10);
    chk("events_drained", ev_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
